// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, response and ALU-side signals of the ALU share arbiter; slave = arbiter, master = requesters/ALU
interface alu_share_arbiter_if #(parameter int W = 32, parameter int SEL_W = 3);
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]     req0_op1, req0_op2, req1_op1, req1_op2;
  logic [SEL_W-1:0] req0_sel, req1_sel;
  logic             rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic             rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [W-1:0]     rsp0_result, rsp1_result;
  logic [W-1:0]     alu_op1, alu_op2, alu_result;
  logic [SEL_W-1:0] alu_sel;
  logic             alu_zero, busy;
  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_sel, req1_valid, req1_op1, req1_op2, req1_sel,
           rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
           rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, alu_op1, alu_op2, alu_sel, busy
  );
  modport master (
    output req0_valid, req0_op1, req0_op2, req0_sel, req1_valid, req1_op1, req1_op2, req1_sel,
           rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
           rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, alu_op1, alu_op2, alu_sel, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters (IDLE->EXEC->RESP), ports clk, rst (async high), bus (alu_share_arbiter_if.slave); ALU_ARB_FIXED_PRIO_EN selects fixed req0 priority instead of round robin
module alu_share_arbiter #(
  parameter int W = 32,
  parameter int SEL_W = 3
) (
  input logic clk,
  input logic rst,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [W-1:0] op1_q, op2_q, res0_q, res1_q;
  logic [SEL_W-1:0] sel_q, sel_in;
  logic id_q, err_q, z0_q, z1_q, e0_q, e1_q, g1, acc, bad, done;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign g1 = bus.req1_valid & ~bus.req0_valid;
`else
  logic last_q;
  assign g1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
`endif
  assign bus.req0_ready = (state == IDLE) & bus.req0_valid & ~g1;
  assign bus.req1_ready = (state == IDLE) & g1;
  assign acc = bus.req0_ready | bus.req1_ready;
  assign sel_in = g1 ? bus.req1_sel : bus.req0_sel;
  assign bad = (sel_in == SEL_W'(0)) | (sel_in == SEL_W'(5));
  assign bus.rsp0_valid = (state == RESP) & ~id_q;
  assign bus.rsp1_valid = (state == RESP) & id_q;
  assign done = (bus.rsp0_valid & bus.rsp0_ready) | (bus.rsp1_valid & bus.rsp1_ready);
  assign bus.rsp0_result = res0_q;
  assign bus.rsp0_zero = z0_q;
  assign bus.rsp0_err = e0_q;
  assign bus.rsp1_result = res1_q;
  assign bus.rsp1_zero = z1_q;
  assign bus.rsp1_err = e1_q;
  assign bus.alu_op1 = op1_q;
  assign bus.alu_op2 = op2_q;
  assign bus.alu_sel = sel_q;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (acc ? EXEC : IDLE) : state == EXEC ? RESP : (done ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op1_q <= '0;
      op2_q <= '0;
      sel_q <= '1;
      id_q <= 1'b0;
      err_q <= 1'b0;
      res0_q <= '0;
      res1_q <= '0;
      z0_q <= 1'b0;
      z1_q <= 1'b0;
      e0_q <= 1'b0;
      e1_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q <= 1'b1;
`endif
    end else begin
      state <= state_n;
      if (acc) begin
        op1_q <= g1 ? bus.req1_op1 : bus.req0_op1;
        op2_q <= g1 ? bus.req1_op2 : bus.req0_op2;
        sel_q <= bad ? '1 : sel_in;
        err_q <= bad;
        id_q <= g1;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_q <= g1;
`endif
      end
      if (state == EXEC && id_q) begin
        res1_q <= bus.alu_result;
        z1_q <= bus.alu_zero;
        e1_q <= err_q;
      end
      if (state == EXEC && !id_q) begin
        res0_q <= bus.alu_result;
        z0_q <= bus.alu_zero;
        e0_q <= err_q;
      end
    end
  end
endmodule
